// File: rtl/kf8259_common_pkg.sv
// Shared types and bit helpers for the KF8259 acknowledge path.
package kf8259_common_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACK1_LOW,
      ACK1_HIGH,
      ACK2_LOW
   } ack_state_e;

   function automatic logic [7:0] rotate_right(input logic [7:0] value, input logic [2:0] amount);
      logic [15:0] wide;
      wide = {value, value} >> amount;
      return wide[7:0];
   endfunction

   function automatic logic [7:0] rotate_left(input logic [7:0] value, input logic [2:0] amount);
      logic [15:0] wide;
      wide = {value, value} << amount;
      return wide[15:8];
   endfunction

   function automatic logic [7:0] level_to_onehot(input logic [2:0] level);
      logic [7:0] onehot;
      onehot = 8'b0000_0001 << level;
      return onehot;
   endfunction

   // Rank 0 is the highest priority; the level just above the rotation point wins.
   function automatic logic [2:0] priority_rank(input logic [2:0] level, input logic [2:0] lowest);
      return level - lowest - 3'd1;
   endfunction

endpackage

// File: rtl/kf8259_priority_resolver.sv
// Finds the highest-priority set bit of an 8-bit vector under a rotating priority order.
module kf8259_priority_resolver
   import kf8259_common_pkg::*;
(
   input  logic [7:0] request_i,
   input  logic [2:0] lowest_priority_level_i,
   output logic       valid_o,
   output logic [2:0] level_o
);

   logic [2:0] start_level;
   logic [7:0] rotated;
   logic [2:0] offset;

   // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
   always_comb begin
      start_level = lowest_priority_level_i + 3'd1;
      rotated     = rotate_right(request_i, start_level);
      offset      = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (rotated[i]) offset = 3'(i);
      end
      level_o = offset + start_level;
      valid_o = |request_i;
   end

endmodule

// File: rtl/kf8259_acknowledge_sequencer.sv
// Priority resolution, INTA two-pulse sequencing, ISR and EOI handling for the KF8259.
// Optional automatic EOI on the second INTA rise is enabled by defining KF8259_AUTO_EOI_EN.
module kf8259_acknowledge_sequencer
   import kf8259_common_pkg::*;
#(
   parameter int VECTOR_WIDTH   = 8,
   parameter int SPURIOUS_LEVEL = 7
) (
   input  logic                    clock_i,
   input  logic                    reset_n_i,
   input  logic [7:0]              interrupt_request_register_i,
   input  logic [7:0]              interrupt_mask_i,
   input  logic [4:0]              vector_base_i,
   input  logic                    interrupt_acknowledge_n_i,
   input  logic                    end_of_interrupt_i,
   input  logic                    specific_eoi_i,
   input  logic [2:0]              eoi_level_i,
   input  logic                    rotate_on_eoi_i,
   input  logic                    auto_eoi_config_i,
   output logic                    freeze_o,
   output logic [7:0]              clear_interrupt_request_o,
   output logic [7:0]              in_service_register_o,
   output logic                    interrupt_o,
   output logic [VECTOR_WIDTH-1:0] vector_out_o,
   output logic                    vector_enable_o,
   output logic [2:0]              lowest_priority_level_o
);

   ack_state_e              state_q, state_d;
   logic                    inta_prev_q;
   logic [2:0]              granted_q, granted_d;
   logic                    spurious_q, spurious_d;
   logic                    freeze_q, freeze_d;
   logic [7:0]              clear_q, clear_d;
   logic [7:0]              isr_q, isr_d;
   logic                    interrupt_q, interrupt_d;
   logic [VECTOR_WIDTH-1:0] vector_q, vector_d;
   logic                    vector_enable_q, vector_enable_d;
   logic [2:0]              lowest_q, lowest_d;

   logic [7:0] eligible;
   logic       req_valid, isr_valid, winner_valid;
   logic [2:0] req_level, isr_level;
   logic       inta_fall, inta_rise;
   logic [7:0] set_mask, clr_mask;
   logic       eoi_hit;
   logic [2:0] eoi_target;

   assign eligible = interrupt_request_register_i & ~interrupt_mask_i;

   kf8259_priority_resolver u_request_resolver (
      .request_i               (eligible),
      .lowest_priority_level_i (lowest_q),
      .valid_o                 (req_valid),
      .level_o                 (req_level)
   );

   kf8259_priority_resolver u_service_resolver (
      .request_i               (isr_q),
      .lowest_priority_level_i (lowest_q),
      .valid_o                 (isr_valid),
      .level_o                 (isr_level)
   );

   // Fully nested: a request must strictly outrank everything already in service.
   assign winner_valid = req_valid &&
      (!isr_valid || (priority_rank(req_level, lowest_q) < priority_rank(isr_level, lowest_q)));

   assign inta_fall = inta_prev_q & ~interrupt_acknowledge_n_i;
   assign inta_rise = ~inta_prev_q & interrupt_acknowledge_n_i;

   always_comb begin
      state_d         = state_q;
      granted_d       = granted_q;
      spurious_d      = spurious_q;
      freeze_d        = freeze_q;
      clear_d         = 8'h00;
      vector_d        = vector_q;
      vector_enable_d = vector_enable_q;
      lowest_d        = lowest_q;
      set_mask        = 8'h00;
      clr_mask        = 8'h00;
      eoi_hit         = 1'b0;
      eoi_target      = isr_level;

      if (end_of_interrupt_i) begin
         if (specific_eoi_i) begin
            eoi_target = eoi_level_i;
            eoi_hit    = isr_q[eoi_level_i];
         end else begin
            eoi_hit    = isr_valid;
         end
         if (eoi_hit) begin
            clr_mask = level_to_onehot(eoi_target);
            if (rotate_on_eoi_i) lowest_d = eoi_target;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (inta_fall) begin
               state_d  = ACK1_LOW;
               freeze_d = 1'b1;
               if (winner_valid) begin
                  granted_d  = req_level;
                  spurious_d = 1'b0;
                  set_mask   = level_to_onehot(req_level);
                  clear_d    = level_to_onehot(req_level);
               end else begin
                  granted_d  = 3'(SPURIOUS_LEVEL);
                  spurious_d = 1'b1;
               end
            end
         end
         ACK1_LOW: begin
            if (inta_rise) state_d = ACK1_HIGH;
         end
         ACK1_HIGH: begin
            if (inta_fall) begin
               vector_d        = VECTOR_WIDTH'({vector_base_i, granted_q});
               vector_enable_d = 1'b1;
               state_d         = ACK2_LOW;
            end
         end
         ACK2_LOW: begin
            if (inta_rise) begin
               vector_enable_d = 1'b0;
               freeze_d        = 1'b0;
               spurious_d      = 1'b0;
               state_d         = IDLE;
`ifdef KF8259_AUTO_EOI_EN
               if (auto_eoi_config_i && !spurious_q) begin
                  clr_mask = clr_mask | level_to_onehot(granted_q);
                  if (rotate_on_eoi_i) lowest_d = granted_q;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // A set on the same bit as a clear wins because it is OR-ed in last.
      isr_d       = (isr_q & ~clr_mask) | set_mask;
      interrupt_d = (state_d == IDLE) && winner_valid;
   end

`ifndef KF8259_AUTO_EOI_EN
   logic unused_auto_eoi;
   assign unused_auto_eoi = auto_eoi_config_i;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q         <= IDLE;
         inta_prev_q     <= 1'b1;
         granted_q       <= 3'd0;
         spurious_q      <= 1'b0;
         freeze_q        <= 1'b0;
         clear_q         <= 8'h00;
         isr_q           <= 8'h00;
         interrupt_q     <= 1'b0;
         vector_q        <= '0;
         vector_enable_q <= 1'b0;
         lowest_q        <= 3'd7;
      end else begin
         state_q         <= state_d;
         inta_prev_q     <= interrupt_acknowledge_n_i;
         granted_q       <= granted_d;
         spurious_q      <= spurious_d;
         freeze_q        <= freeze_d;
         clear_q         <= clear_d;
         isr_q           <= isr_d;
         interrupt_q     <= interrupt_d;
         vector_q        <= vector_d;
         vector_enable_q <= vector_enable_d;
         lowest_q        <= lowest_d;
      end
   end

   assign freeze_o                  = freeze_q;
   assign clear_interrupt_request_o = clear_q;
   assign in_service_register_o     = isr_q;
   assign interrupt_o               = interrupt_q;
   assign vector_out_o              = vector_q;
   assign vector_enable_o           = vector_enable_q;
   assign lowest_priority_level_o   = lowest_q;

endmodule

// File: tb/tb_kf8259_acknowledge_sequencer.sv
// Scoreboard bench: stimulus pushes expected clear pulses and vectors, a monitor pops and compares.
module tb_kf8259_acknowledge_sequencer;

   localparam logic KIND_CLR = 1'b0;
   localparam logic KIND_VEC = 1'b1;

   typedef struct {
      logic       kind;
      logic [7:0] value;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] irr, mask;
   logic [4:0] base;
   logic       inta_n, eoi, specific, rotate, aeoi;
   logic [2:0] eoi_lvl;
   logic       freeze, interrupt, vec_en;
   logic [7:0] clear, isr, vector_out;
   logic [2:0] lowest;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   kf8259_acknowledge_sequencer dut (
      .clock_i                      (clk),
      .reset_n_i                    (rst_n),
      .interrupt_request_register_i (irr),
      .interrupt_mask_i             (mask),
      .vector_base_i                (base),
      .interrupt_acknowledge_n_i    (inta_n),
      .end_of_interrupt_i           (eoi),
      .specific_eoi_i               (specific),
      .eoi_level_i                  (eoi_lvl),
      .rotate_on_eoi_i              (rotate),
      .auto_eoi_config_i            (aeoi),
      .freeze_o                     (freeze),
      .clear_interrupt_request_o    (clear),
      .in_service_register_o        (isr),
      .interrupt_o                  (interrupt),
      .vector_out_o                 (vector_out),
      .vector_enable_o              (vec_en),
      .lowest_priority_level_o      (lowest)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic compare_event(input logic kind, input logic [7:0] value);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_unexpected: got kind %0d value 0x%0h, required no output", kind, value);
      end else begin
         e = sb.pop_front();
         check("sb_kind", 32'(kind), 32'(e.kind));
         check("sb_value", 32'(value), 32'(e.value));
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic kind, input logic [7:0] value);
      exp_t e;
      e.kind  = kind;
      e.value = value;
      sb.push_back(e);
   endtask

   // Full two-pulse INTA sequence; spurious sequences produce no clear pulse.
   task automatic inta_pair(input logic spurious, input logic [7:0] clr_exp, input logic [7:0] vec_exp);
      if (!spurious) push(KIND_CLR, clr_exp);
      inta_n = 1'b0;
      step(1);
      check("freeze_after_fall1", 32'(freeze), 32'd1);
      step(2);
      inta_n = 1'b1;
      step(2);
      check("freeze_after_rise1", 32'(freeze), 32'd1);
      push(KIND_VEC, vec_exp);
      inta_n = 1'b0;
      step(3);
      check("vec_en_held", 32'(vec_en), 32'd1);
      inta_n = 1'b1;
      step(1);
      check("freeze_after_rise2", 32'(freeze), 32'd0);
      check("vec_en_after_rise2", 32'(vec_en), 32'd0);
   endtask

   task automatic eoi_cmd(input logic spec, input logic [2:0] lvl, input logic rot);
      eoi      = 1'b1;
      specific = spec;
      eoi_lvl  = lvl;
      rotate   = rot;
      step(1);
      eoi      = 1'b0;
      specific = 1'b0;
      rotate   = 1'b0;
   endtask

   initial begin : monitor
      logic ve_prev;
      ve_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ve_prev = 1'b0;
         end else begin
            if (clear != 8'h00) compare_event(KIND_CLR, clear);
            if (vec_en && !ve_prev) compare_event(KIND_VEC, vector_out);
            ve_prev = vec_en;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      rst_n = 1'b0; irr = 8'h00; mask = 8'h00; base = 5'h01; inta_n = 1'b1;
      eoi = 1'b0; specific = 1'b0; eoi_lvl = 3'd0; rotate = 1'b0; aeoi = 1'b0;
      step(3);
      check("rst_freeze", 32'(freeze), 32'd0);
      check("rst_clear", 32'(clear), 32'h00);
      check("rst_isr", 32'(isr), 32'h00);
      check("rst_interrupt", 32'(interrupt), 32'd0);
      check("rst_vector", 32'(vector_out), 32'h00);
      check("rst_vec_en", 32'(vec_en), 32'd0);
      check("rst_lowest", 32'(lowest), 32'd7);
      rst_n = 1'b1;
      step(1);

      // IR3 wins over IR5 at default priority.
      irr = 8'h28;
      step(2);
      check("t1_interrupt", 32'(interrupt), 32'd1);
      inta_pair(1'b0, 8'h08, 8'h0B);
      check("t1_isr", 32'(isr), 32'h08);
      irr = 8'h20;
      step(2);
      check("t1_nested_block", 32'(interrupt), 32'd0);
      irr = 8'h00;
      eoi_cmd(1'b0, 3'd0, 1'b0);
      check("t1_isr_after_eoi", 32'(isr), 32'h00);

      // Equal level in service blocks; non-specific EOI releases it.
      irr = 8'h01;
      step(2);
      inta_pair(1'b0, 8'h01, 8'h08);
      step(2);
      check("t2_isr", 32'(isr), 32'h01);
      check("t2_blocked", 32'(interrupt), 32'd0);
      eoi_cmd(1'b0, 3'd0, 1'b0);
      check("t2_isr_cleared", 32'(isr), 32'h00);
      step(1);
      check("t2_interrupt", 32'(interrupt), 32'd1);
      irr = 8'h00;
      step(2);

      // Request withdrawn before the first INTA: spurious IR7 vector.
      irr = 8'h04;
      step(2);
      check("t3_interrupt", 32'(interrupt), 32'd1);
      irr = 8'h00;
      step(1);
      inta_pair(1'b1, 8'h00, 8'h0F);
      check("t3_isr", 32'(isr), 32'h00);

      // Build ISR=0x12, specific EOI on 4 with rotation, then IR5 beats IR0.
      irr = 8'h10;
      step(2);
      inta_pair(1'b0, 8'h10, 8'h0C);
      irr = 8'h02;
      step(2);
      check("t4_ir1_preempts", 32'(interrupt), 32'd1);
      inta_pair(1'b0, 8'h02, 8'h09);
      irr = 8'h00;
      check("t4_isr_built", 32'(isr), 32'h12);
      eoi_cmd(1'b1, 3'd4, 1'b1);
      check("t4_isr_after_eoi", 32'(isr), 32'h02);
      check("t4_lowest", 32'(lowest), 32'd4);
      irr = 8'h21;
      step(2);
      check("t4_interrupt", 32'(interrupt), 32'd1);
      inta_pair(1'b0, 8'h20, 8'h0D);
      check("t4_isr_final", 32'(isr), 32'h22);
      irr = 8'h00;

      // Automatic EOI.
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
      check("t5_lowest_reset", 32'(lowest), 32'd7);
      aeoi = 1'b1;
      irr  = 8'h04;
      step(2);
      inta_pair(1'b0, 8'h04, 8'h0A);
`ifdef KF8259_AUTO_EOI_EN
      check("t5_isr_aeoi", 32'(isr), 32'h00);
`else
      check("t5_isr_no_aeoi", 32'(isr), 32'h04);
`endif
      check("t5_lowest", 32'(lowest), 32'd7);
      aeoi = 1'b0;
      irr  = 8'h00;
      eoi_cmd(1'b0, 3'd0, 1'b0);
      step(1);

      // Reset asserted in ACK1_HIGH, then a clean sequence.
      irr = 8'h08;
      step(2);
      push(KIND_CLR, 8'h08);
      inta_n = 1'b0;
      step(2);
      inta_n = 1'b1;
      step(2);
      check("t6_freeze_before_rst", 32'(freeze), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_freeze_async", 32'(freeze), 32'd0);
      check("t6_isr_async", 32'(isr), 32'h00);
      step(2);
      rst_n = 1'b1;
      step(2);
      check("t6_interrupt", 32'(interrupt), 32'd1);
      inta_pair(1'b0, 8'h08, 8'h0B);
      check("t6_isr", 32'(isr), 32'h08);
      irr = 8'h00;
      step(3);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/kf8259_acknowledge_sequencer.md
Name: kf8259_acknowledge_sequencer

Overview:
- Priority resolver and INTA-cycle sequencer that sits between the interrupt request latch and the 8086-side bus interface of the KF8259.
- Selects the highest-priority unmasked request and drives the interrupt line.
- Runs the two-pulse INTA handshake, sets the in-service register, clears the granted request bit and supplies the vector byte.
- Services EOI commands, including optional priority rotation.

Parameters:
- VECTOR_WIDTH, 8, width of the vector byte driven on the second INTA pulse.
- SPURIOUS_LEVEL, 7, level reported when no request survives to the first INTA.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- interrupt_request_register  in  8  latched requests.
- interrupt_mask  in  8  1 = level masked.
- vector_base  in  5  vector bits [7:3] (T7..T3).
- interrupt_acknowledge_n  in  1  INTA pin, active low, already synchronised.
- end_of_interrupt  in  1  one-cycle EOI command strobe.
- specific_eoi  in  1  qualifies the strobe: 1 = clear eoi_level, 0 = non-specific.
- eoi_level  in  3  level for specific EOI.
- rotate_on_eoi  in  1  make the cleared level lowest priority.
- auto_eoi_config  in  1  AEOI mode (used only with the macro).
- freeze  out  1  holds the request latch during the INTA sequence.
- clear_interrupt_request  out  8  one-hot, one-cycle clear to the request latch.
- in_service_register  out  8  ISR.
- interrupt  out  1  INT to the CPU.
- vector_out  out  8  {vector_base, level}.
- vector_enable  out  1  vector_out is valid on the bus.
- lowest_priority_level  out  3  current rotation point.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - freeze=0, clear_interrupt_request=0, in_service_register=0, interrupt=0, vector_out=0, vector_enable=0.
  - lowest_priority_level=7, so IR0 is highest priority.
  - State=IDLE, internal INTA-previous register=1.
- Priority order:
  - Highest level = lowest_priority_level+1 mod 8, descending cyclically from there.
  - eligible = interrupt_request_register & ~interrupt_mask.
- interrupt (registered, 1-cycle latency):
  - 1 when state=IDLE and the top eligible level outranks the top ISR level (fully nested); ISR empty counts as lowest.
  - Forced 0 outside IDLE.
- INTA edge detection: fall = prev & ~interrupt_acknowledge_n; rise = ~prev & interrupt_acknowledge_n.
- IDLE:
  - On fall, latch the winner (top eligible level that passes the nesting check) into granted_level.
  - If there is none, granted_level=SPURIOUS_LEVEL and the spurious flag is set.
  - On the next edge: freeze=1, ISR[granted]=1 and clear_interrupt_request[granted]=1 for exactly one cycle. Both are skipped if spurious.
  - Go to ACK1_LOW.
- ACK1_LOW: on rise, go to ACK1_HIGH.
- ACK1_HIGH: on fall, vector_out={vector_base, granted_level} and vector_enable=1; go to ACK2_LOW.
- ACK2_LOW:
  - vector_enable stays 1 while INTA is low.
  - On rise: vector_enable=0, freeze=0, spurious flag cleared, return to IDLE.
- EOI strobe, accepted in any state:
  - Non-specific clears the top-priority set ISR bit; specific clears ISR[eoi_level].
  - If the selected bit is already 0 (or ISR is empty), it is a no-op and rotation is unchanged.
  - If rotate_on_eoi and a bit was cleared, lowest_priority_level = cleared level.
- EOI and an ISR set on the same bit in the same cycle: set wins. Different bits: both apply.
- The state machine ignores INTA edges that do not match the current state.
- Reset asserted mid-sequence returns everything to reset values immediately; freeze drops asynchronously.

Optional Feature:
- Macro: KF8259_AUTO_EOI_EN.
- When defined: if auto_eoi_config=1, the rise that ends ACK2_LOW clears ISR[granted_level]. If rotate_on_eoi=1, that clear also sets lowest_priority_level=granted_level.
- When undefined: the auto_eoi_config port remains but is ignored, and the ISR clears only via EOI.

Decomposition:
- Package kf8259_common_pkg holds:
  - the state enum (IDLE, ACK1_LOW, ACK1_HIGH, ACK2_LOW);
  - rotate-right/rotate-left functions over 8 bits;
  - the level-to-one-hot function.
- One sub-module, kf8259_priority_resolver: combinational; inputs an 8-bit vector and lowest_priority_level; outputs a valid flag and a 3-bit top level. Instanced twice, once for eligible requests and once for the ISR.

Test Plan:
- IRR=0x28, mask=0, ISR=0 -> interrupt=1; two INTA pulses with vector_base=0x01 -> ISR=0x08, clear pulse 0x08 for one cycle, vector_out=0x0B, freeze=1 from the first fall until the second rise.
- IRR=0x01 with ISR=0x01 -> interrupt stays 0. Then IRR=0x01 after non-specific EOI -> interrupt=1 one cycle later.
- Request withdrawn before first INTA (IRR=0) -> spurious: ISR unchanged, no clear pulse, vector_out={vector_base,3'd7}.
- ISR=0x12, specific EOI level 4 with rotate_on_eoi=1 -> ISR=0x02, lowest_priority_level=4; then IRR=0x21 -> winner is IR5.
- With KF8259_AUTO_EOI_EN and auto_eoi_config=1, IRR=0x04 -> after the second INTA rise ISR=0x00; without the macro -> ISR=0x04.
- reset_n pulsed low during ACK1_HIGH -> freeze=0, ISR=0, state IDLE; the next INTA pair is serviced normally.
